id_stage_hazard: RTL
====================

// Module: id_stage_hazard
// PURPOSE
//  Parametrised MIPS instruction-decode stage, successor to the single-issue ID block.
//  - Owns the register file (write-through bypass) and the ID/EX pipeline register.
//  - Resolves branches/jumps in ID using EX/MEM forwarding.
//  - Detects load-use and branch-operand hazards and inserts bubbles.
//  - Sits between IF/ID and EX; outputs feed the EX stage and the PC mux.
// PARAMETERS
//  NB_DATA  32  datapath/register width
//  NB_ADDR  5   register index width; register file depth = 2**NB_ADDR
//  NB_IMM   16  immediate field width (instruction[NB_IMM-1:0])
//  RA_IDX   31  link register written by JAL
// PORTS
//  clk          in   1        clock, rising edge
//  i_rst_n      in   1        asynchronous, active-low reset
//  i_valid      in   1        IF/ID holds a valid instruction
//  i_instruction in  NB_DATA  instruction word
//  i_pc4        in   NB_DATA  PC+4 of the instruction
//  i_stall      in   1        downstream freeze; hold ID/EX register
//  i_flush      in   1        squash ID/EX contents (load bubble)
//  i_wb_we      in   1        writeback write enable
//  i_wb_addr    in   NB_ADDR  writeback register index
//  i_wb_data    in   NB_DATA  writeback data
//  i_ex_we      in   1        instruction in EX writes a register
//  i_ex_memread in   1        instruction in EX is a load
//  i_ex_dst     in   NB_ADDR  destination index of instruction in EX
//  i_mem_we     in   1        instruction in MEM writes a register
//  i_mem_memread in  1        instruction in MEM is a load
//  i_mem_dst    in   NB_ADDR  destination index of instruction in MEM
//  i_mem_data   in   NB_DATA  ALU result in MEM (branch forwarding)
//  o_hazard     out  1        combinational; hold PC and IF/ID this cycle
//  o_jump       out  1        combinational; redirect PC to o_jump_addr
//  o_jump_addr  out  NB_DATA  combinational jump/branch target
//  o_valid      out  1        ID/EX holds a valid instruction
//  o_rs/o_rt/o_rd out NB_ADDR registered source/target/destination indices
//  o_da/o_db    out  NB_DATA  registered operand values
//  o_imm        out  NB_DATA  registered extended immediate
//  o_opcode/o_func out 6      registered opcode/funct
//  o_shamt      out  5        registered shift amount
// BEHAVIOUR
//  - Reset: every registered output 0, o_valid=0; register file cleared to 0.
//    Async assertion mid-operation clears immediately.
//  - Register file:
//    - Reg 0 reads 0; writes to it are ignored.
//    - Write on posedge when i_wb_we.
//    - Same-cycle read of i_wb_addr returns i_wb_data (bypass).
//  - Immediate: zero-extended for ANDI/ORI/XORI (0x0C/0x0D/0x0E); sign-extended otherwise.
//  - Load-use hazard:
//    - Condition: i_valid & i_ex_memread & i_ex_dst!=0, and i_ex_dst matches rs,
//      or matches rt when rt is a source (R-type, BEQ, BNE, stores).
//    - Response: o_hazard=1.
//  - Branch hazard: BEQ/BNE/JR/JALR operand matches a nonzero dst of either
//    - EX with i_ex_we, or
//    - MEM with i_mem_memread
//    -> o_hazard=1. An EX load therefore costs 2 bubbles; an EX ALU op costs 1.
//  - Branch forwarding: MEM non-load match (i_mem_we) takes i_mem_data;
//    otherwise the register-file/bypass value is used.
//  - Jumps (only when i_valid & !o_hazard & !i_stall):
//    - BEQ/BNE taken: target = i_pc4 + (sext(imm)<<2).
//    - J/JAL: target = {i_pc4[31:28], instr[25:0], 2'b00}.
//    - JR/JALR: target = forwarded rs.
//    - o_jump=1 only on a taken branch or any jump; o_jump_addr=0 when o_jump=0.
//  - Link: JAL/JALR -> o_da=i_pc4, o_db=4, o_rs=0.
//    Destination: JAL o_rt=RA_IDX; JALR o_rd=rd.
//  - ID/EX update priority, per posedge:
//    reset > i_flush (o_valid=0, fields 0) > i_stall (hold all)
//    > o_hazard or !i_valid (bubble: o_valid=0, fields 0) > load decoded fields.
//  - Latency: operands/fields appear 1 cycle after i_valid; o_jump is same-cycle.
// TESTING
//  1. Reset mid-stream: rst_n low with o_valid=1 -> all outputs 0 asynchronously; reg reads 0.
//  2. WB bypass: wb_we=1, addr=5, data=0xDEAD while decoding ADD rs=5 -> o_da=0xDEAD next cycle.
//  3. Load-use: ex_memread=1, ex_dst=3, ADD rs=3 -> o_hazard=1, next o_valid=0;
//     clear ex_memread -> decodes.
//  4. BEQ forwarding: mem_we=1, mem_dst=4, mem_data=7, reg8=7, BEQ r4,r8,imm=-2, pc4=0x100
//     -> o_jump=1, o_jump_addr=0xF8.
//  5. JAL: instr=0x0C000010, pc4=0x2000_0004 -> o_jump_addr=0x2000_0040;
//     next cycle o_rt=31, o_da=0x2000_0004, o_db=4.
//  6. Priority: i_flush & i_stall & hazard together -> o_valid=0;
//     i_stall alone holds the prior ID/EX contents.

Source files
------------

// File: rtl/id_stage_hazard_if.sv
// IF/ID -> ID -> EX/PC-mux bus for the decode stage. The slave modport is the
// decode stage itself; the master modport is whatever surrounds it.
interface id_stage_hazard_if #(
    parameter int unsigned NB_DATA = 32,
    parameter int unsigned NB_ADDR = 5
);
    // IF/ID side
    logic               i_valid;
    logic [NB_DATA-1:0] i_instruction;
    logic [NB_DATA-1:0] i_pc4;
    logic               i_stall;
    logic               i_flush;
    // Writeback port
    logic               i_wb_we;
    logic [NB_ADDR-1:0] i_wb_addr;
    logic [NB_DATA-1:0] i_wb_data;
    // EX / MEM occupancy for hazard detection and branch forwarding
    logic               i_ex_we;
    logic               i_ex_memread;
    logic [NB_ADDR-1:0] i_ex_dst;
    logic               i_mem_we;
    logic               i_mem_memread;
    logic [NB_ADDR-1:0] i_mem_dst;
    logic [NB_DATA-1:0] i_mem_data;
    // Combinational control to the PC / IF stage
    logic               o_hazard;
    logic               o_jump;
    logic [NB_DATA-1:0] o_jump_addr;
    // ID/EX register
    logic               o_valid;
    logic [NB_ADDR-1:0] o_rs;
    logic [NB_ADDR-1:0] o_rt;
    logic [NB_ADDR-1:0] o_rd;
    logic [NB_DATA-1:0] o_da;
    logic [NB_DATA-1:0] o_db;
    logic [NB_DATA-1:0] o_imm;
    logic [5:0]         o_opcode;
    logic [5:0]         o_func;
    logic [4:0]         o_shamt;

    modport slave (
        input  i_valid, i_instruction, i_pc4, i_stall, i_flush,
        input  i_wb_we, i_wb_addr, i_wb_data,
        input  i_ex_we, i_ex_memread, i_ex_dst,
        input  i_mem_we, i_mem_memread, i_mem_dst, i_mem_data,
        output o_hazard, o_jump, o_jump_addr,
        output o_valid, o_rs, o_rt, o_rd, o_da, o_db, o_imm, o_opcode, o_func, o_shamt
    );

    modport master (
        output i_valid, i_instruction, i_pc4, i_stall, i_flush,
        output i_wb_we, i_wb_addr, i_wb_data,
        output i_ex_we, i_ex_memread, i_ex_dst,
        output i_mem_we, i_mem_memread, i_mem_dst, i_mem_data,
        input  o_hazard, o_jump, o_jump_addr,
        input  o_valid, o_rs, o_rt, o_rd, o_da, o_db, o_imm, o_opcode, o_func, o_shamt
    );
endinterface

// File: rtl/id_stage_hazard.sv
// MIPS instruction-decode stage: register file with write-through bypass,
// load-use / branch-operand hazard detection, branch and jump resolution with
// MEM-stage forwarding, and the ID/EX pipeline register.
module id_stage_hazard #(
    parameter int unsigned NB_DATA = 32,
    parameter int unsigned NB_ADDR = 5,
    parameter int unsigned NB_IMM  = 16,
    parameter int unsigned RA_IDX  = 31
) (
    input logic              clk,
    input logic              i_rst_n,
    id_stage_hazard_if.slave bus
);
    localparam int unsigned NREGS = 2 ** NB_ADDR;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SH    = 6'h29;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_JALR  = 6'h09;

    typedef struct packed {
        logic               valid;
        logic [NB_ADDR-1:0] rs;
        logic [NB_ADDR-1:0] rt;
        logic [NB_ADDR-1:0] rd;
        logic [NB_DATA-1:0] da;
        logic [NB_DATA-1:0] db;
        logic [NB_DATA-1:0] imm;
        logic [5:0]         opcode;
        logic [5:0]         func;
        logic [4:0]         shamt;
    } idex_t;

    logic [NB_DATA-1:0] rf_q [NREGS];
    logic [NB_DATA-1:0] rf_d [NREGS];
    idex_t              idex_q, idex_d;

    // Instruction fields
    logic [5:0]         opcode, func;
    logic [NB_ADDR-1:0] rs, rt, rd;
    logic [4:0]         shamt;
    logic [NB_IMM-1:0]  imm_raw;
    logic [NB_DATA-1:0] imm_sext, imm_ext;

    assign opcode  = bus.i_instruction[31:26];
    assign rs      = bus.i_instruction[25:21];
    assign rt      = bus.i_instruction[20:16];
    assign rd      = bus.i_instruction[15:11];
    assign shamt   = bus.i_instruction[10:6];
    assign func    = bus.i_instruction[5:0];
    assign imm_raw = bus.i_instruction[NB_IMM-1:0];

    assign imm_sext = {{(NB_DATA-NB_IMM){imm_raw[NB_IMM-1]}}, imm_raw};
    assign imm_ext  = (opcode == OP_ANDI || opcode == OP_ORI || opcode == OP_XORI)
                      ? {{(NB_DATA-NB_IMM){1'b0}}, imm_raw} : imm_sext;

    // Instruction class decode
    logic is_rtype, is_jr, is_jalr, is_j, is_jal, is_beq, is_bne, is_store;
    logic rt_is_src, is_cond_br, needs_rs_now;

    assign is_rtype   = (opcode == OP_RTYPE);
    assign is_jr      = is_rtype && (func == FN_JR);
    assign is_jalr    = is_rtype && (func == FN_JALR);
    assign is_j       = (opcode == OP_J);
    assign is_jal     = (opcode == OP_JAL);
    assign is_beq     = (opcode == OP_BEQ);
    assign is_bne     = (opcode == OP_BNE);
    assign is_store   = (opcode == OP_SB) || (opcode == OP_SH) || (opcode == OP_SW);
    assign rt_is_src  = is_rtype || is_beq || is_bne || is_store;
    assign is_cond_br = is_beq || is_bne;
    // Instructions whose operands are consumed in ID rather than EX
    assign needs_rs_now = is_cond_br || is_jr || is_jalr;

    // Register reads: reg 0 is hard-wired, a same-cycle writeback bypasses the array
    logic [NB_DATA-1:0] rf_rs, rf_rt;
    assign rf_rs = (rs == '0) ? '0
                 : (bus.i_wb_we && bus.i_wb_addr == rs) ? bus.i_wb_data : rf_q[rs];
    assign rf_rt = (rt == '0) ? '0
                 : (bus.i_wb_we && bus.i_wb_addr == rt) ? bus.i_wb_data : rf_q[rt];

    // Hazard and forwarding match terms
    logic ex_nz, mem_nz;
    logic load_use, br_hazard, hazard;
    logic ex_hit_rs, ex_hit_rt, mem_ld_rs, mem_ld_rt, mem_fwd_rs, mem_fwd_rt;
    logic [NB_DATA-1:0] fwd_rs, fwd_rt;

    assign ex_nz      = (bus.i_ex_dst != '0);
    assign mem_nz     = (bus.i_mem_dst != '0);
    assign ex_hit_rs  = bus.i_ex_we && ex_nz && (bus.i_ex_dst == rs);
    assign ex_hit_rt  = bus.i_ex_we && ex_nz && (bus.i_ex_dst == rt);
    assign mem_ld_rs  = bus.i_mem_memread && mem_nz && (bus.i_mem_dst == rs);
    assign mem_ld_rt  = bus.i_mem_memread && mem_nz && (bus.i_mem_dst == rt);
    assign mem_fwd_rs = bus.i_mem_we && !bus.i_mem_memread && mem_nz && (bus.i_mem_dst == rs);
    assign mem_fwd_rt = bus.i_mem_we && !bus.i_mem_memread && mem_nz && (bus.i_mem_dst == rt);

    assign load_use  = bus.i_ex_memread && ex_nz
                       && ((bus.i_ex_dst == rs) || (rt_is_src && bus.i_ex_dst == rt));
    assign br_hazard = needs_rs_now
                       && (ex_hit_rs || mem_ld_rs || (is_cond_br && (ex_hit_rt || mem_ld_rt)));
    assign hazard    = bus.i_valid && (load_use || br_hazard);

    assign fwd_rs = mem_fwd_rs ? bus.i_mem_data : rf_rs;
    assign fwd_rt = mem_fwd_rt ? bus.i_mem_data : rf_rt;

    assign bus.o_hazard = hazard;

    // Branch / jump resolution, suppressed while stalled or stalling
    always_comb begin
        logic go;
        go              = bus.i_valid && !hazard && !bus.i_stall;
        bus.o_jump      = 1'b0;
        bus.o_jump_addr = '0;
        if (go) begin
            if ((is_beq && fwd_rs == fwd_rt) || (is_bne && fwd_rs != fwd_rt)) begin
                bus.o_jump      = 1'b1;
                bus.o_jump_addr = bus.i_pc4 + (imm_sext << 2);
            end else if (is_j || is_jal) begin
                bus.o_jump      = 1'b1;
                bus.o_jump_addr = {bus.i_pc4[NB_DATA-1:28], bus.i_instruction[25:0], 2'b00};
            end else if (is_jr || is_jalr) begin
                bus.o_jump      = 1'b1;
                bus.o_jump_addr = fwd_rs;
            end
        end
    end

    // Register file next state; writes to reg 0 are dropped
    always_comb begin
        rf_d = rf_q;
        if (bus.i_wb_we && bus.i_wb_addr != '0) begin
            rf_d[bus.i_wb_addr] = bus.i_wb_data;
        end
    end

    // Register file storage
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            rf_q <= rf_d;
        end
    end

    // ID/EX next state: flush > stall > bubble > load decoded instruction
    always_comb begin
        idex_d = idex_q;
        if (bus.i_flush) begin
            idex_d = '0;
        end else if (bus.i_stall) begin
            idex_d = idex_q;
        end else if (hazard || !bus.i_valid) begin
            idex_d = '0;
        end else begin
            idex_d.valid  = 1'b1;
            idex_d.rs     = rs;
            idex_d.rt     = rt;
            idex_d.rd     = rd;
            idex_d.da     = rf_rs;
            idex_d.db     = rf_rt;
            idex_d.imm    = imm_ext;
            idex_d.opcode = opcode;
            idex_d.func   = func;
            idex_d.shamt  = shamt;
            // Link instructions carry the return address through the ALU as pc4 + 0... + 4
            if (is_jal || is_jalr) begin
                idex_d.da = bus.i_pc4;
                idex_d.db = NB_DATA'(4);
                idex_d.rs = '0;
            end
            if (is_jal) begin
                idex_d.rt = NB_ADDR'(RA_IDX);
            end
        end
    end

    // ID/EX register
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            idex_q <= '0;
        end else begin
            idex_q <= idex_d;
        end
    end

    assign bus.o_valid  = idex_q.valid;
    assign bus.o_rs     = idex_q.rs;
    assign bus.o_rt     = idex_q.rt;
    assign bus.o_rd     = idex_q.rd;
    assign bus.o_da     = idex_q.da;
    assign bus.o_db     = idex_q.db;
    assign bus.o_imm    = idex_q.imm;
    assign bus.o_opcode = idex_q.opcode;
    assign bus.o_func   = idex_q.func;
    assign bus.o_shamt  = idex_q.shamt;

endmodule
